// File: rtl/alu_issue_stage.sv
// Issue stage in front of the 32-bit ALU: registered operands/select, valid/ready
// handshake with a 1-entry skid buffer, result forwarding and reserved-op rejection.
module alu_issue_stage #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned RADDR_W = 4,
  parameter int unsigned FWD_EN  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_op,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [RADDR_W-1:0] in_rs_a,
  input  logic [RADDR_W-1:0] in_rs_b,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [WIDTH-1:0]   in_imm,
  input  logic               in_use_imm,
  input  logic [WIDTH-1:0]   alu_c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic               s3,
  output logic               s2,
  output logic               s1,
  output logic               s0,
  output logic [RADDR_W-1:0] out_rd,
  output logic               illegal_op,
  input  logic               clr_err
);

  // Output register
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [3:0]         op_q, op_d;
  logic [RADDR_W-1:0] rd_q, rd_d;

  // Skid register
  logic               sk_valid_q, sk_valid_d;
  logic [3:0]         sk_op_q, sk_op_d;
  logic [RADDR_W-1:0] sk_rd_q, sk_rd_d, sk_rs_a_q, sk_rs_a_d, sk_rs_b_q, sk_rs_b_d;
  logic [WIDTH-1:0]   sk_a_q, sk_a_d, sk_b_q, sk_b_d, sk_imm_q, sk_imm_d;
  logic               sk_use_imm_q, sk_use_imm_d;

  logic               illegal_q, illegal_d;

  // Move source for the output register and handshake terms
  logic               accept, fire, in_legal, load_out, src_valid, fwd_a, fwd_b;
  logic [3:0]         src_op;
  logic [RADDR_W-1:0] src_rd, src_rs_a, src_rs_b;
  logic [WIDTH-1:0]   src_a, src_b, src_imm;
  logic               src_use_imm;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b1000, 4'b1001, 4'b1010,
      4'b1011, 4'b1100, 4'b1101, 4'b1110: op_legal = 1'b1;
      default:                            op_legal = 1'b0;
    endcase
  endfunction

  always_comb begin
    accept   = in_valid & ~sk_valid_q;
    fire     = out_valid_q & out_ready;
    in_legal = op_legal(in_op);
    load_out = ~out_valid_q | fire;

    if (sk_valid_q) begin
      src_op      = sk_op_q;
      src_rd      = sk_rd_q;
      src_rs_a    = sk_rs_a_q;
      src_rs_b    = sk_rs_b_q;
      src_a       = sk_a_q;
      src_b       = sk_b_q;
      src_imm     = sk_imm_q;
      src_use_imm = sk_use_imm_q;
    end else begin
      src_op      = in_op;
      src_rd      = in_rd;
      src_rs_a    = in_rs_a;
      src_rs_b    = in_rs_b;
      src_a       = in_a;
      src_b       = in_b;
      src_imm     = in_imm;
      src_use_imm = in_use_imm;
    end
    src_valid = sk_valid_q | (accept & in_legal);

    // The instruction leaving on this edge is the only one not yet in the register file
    fwd_a = (FWD_EN != 0) & fire & (rd_q != '0) & (rd_q == src_rs_a);
    fwd_b = (FWD_EN != 0) & fire & (rd_q != '0) & (rd_q == src_rs_b) & ~src_use_imm;

    out_valid_d  = out_valid_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    rd_d         = rd_q;
    sk_valid_d   = sk_valid_q;
    sk_op_d      = sk_op_q;
    sk_rd_d      = sk_rd_q;
    sk_rs_a_d    = sk_rs_a_q;
    sk_rs_b_d    = sk_rs_b_q;
    sk_a_d       = sk_a_q;
    sk_b_d       = sk_b_q;
    sk_imm_d     = sk_imm_q;
    sk_use_imm_d = sk_use_imm_q;
    illegal_d    = illegal_q;

    if (load_out) begin
      out_valid_d = src_valid;
      if (src_valid) begin
        a_d  = fwd_a ? alu_c : src_a;
        b_d  = src_use_imm ? src_imm : (fwd_b ? alu_c : src_b);
        op_d = src_op;
        rd_d = src_rd;
      end
      if (sk_valid_q) sk_valid_d = 1'b0;
    end

    if (accept & in_legal & out_valid_q & ~out_ready) begin
      sk_valid_d   = 1'b1;
      sk_op_d      = in_op;
      sk_rd_d      = in_rd;
      sk_rs_a_d    = in_rs_a;
      sk_rs_b_d    = in_rs_b;
      sk_a_d       = in_a;
      sk_b_d       = in_b;
      sk_imm_d     = in_imm;
      sk_use_imm_d = in_use_imm;
    end

    if (accept & ~in_legal) illegal_d = 1'b1;
    else if (clr_err)       illegal_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      rd_q         <= '0;
      sk_valid_q   <= 1'b0;
      sk_op_q      <= '0;
      sk_rd_q      <= '0;
      sk_rs_a_q    <= '0;
      sk_rs_b_q    <= '0;
      sk_a_q       <= '0;
      sk_b_q       <= '0;
      sk_imm_q     <= '0;
      sk_use_imm_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      rd_q         <= rd_d;
      sk_valid_q   <= sk_valid_d;
      sk_op_q      <= sk_op_d;
      sk_rd_q      <= sk_rd_d;
      sk_rs_a_q    <= sk_rs_a_d;
      sk_rs_b_q    <= sk_rs_b_d;
      sk_a_q       <= sk_a_d;
      sk_b_q       <= sk_b_d;
      sk_imm_q     <= sk_imm_d;
      sk_use_imm_q <= sk_use_imm_d;
      illegal_q    <= illegal_d;
    end
  end

  assign in_ready   = ~sk_valid_q;
  assign out_valid  = out_valid_q;
  assign a          = a_q;
  assign b          = b_q;
  assign {s3, s2, s1, s0} = op_q;
  assign out_rd     = rd_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed issues push expected operands,
// a negedge monitor pops and compares on every fire.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [3:0]  rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [3:0]  in_rd = '0, in_rs_a = '0, in_rs_b = '0;
  logic [31:0] in_a = '0, in_b = '0, in_imm = '0;
  logic        in_use_imm = 1'b0;
  logic [31:0] alu_c = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] a, b;
  logic        s3, s2, s1, s0;
  logic [3:0]  out_rd;
  logic        illegal_op;
  logic        clr_err = 1'b0;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs_a(in_rs_a), .in_rs_b(in_rs_b),
    .in_a(in_a), .in_b(in_b), .in_imm(in_imm), .in_use_imm(in_use_imm),
    .alu_c(alu_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .s3(s3), .s2(s2), .s1(s1), .s0(s0),
    .out_rd(out_rd), .illegal_op(illegal_op), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rsa,
                       input logic [3:0] rsb, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] imm, input logic ui);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs_a = rsa; in_rs_b = rsb;
    in_a = va; in_b = vb; in_imm = imm; in_use_imm = ui;
  endtask

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL accept_timeout: in_ready stayed %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rsa,
                      input logic [3:0] rsb, input logic [31:0] va, input logic [31:0] vb,
                      input logic [31:0] imm, input logic ui);
    drive(op, rd, rsa, rsb, va, vb, imm, ui);
    wait_accept();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every fire must match the oldest expected entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_issue: a=%h b=%h s=%b rd=%0d with nothing expected",
                   a, b, {s3, s2, s1, s0}, out_rd);
        end else begin
          e = exp_q.pop_front();
          if ({a, b, s3, s2, s1, s0, out_rd} !== e) begin
            failures++;
            $display("FAIL issue: got a=%h b=%h s=%b rd=%0d expected a=%h b=%h s=%b rd=%0d",
                     a, b, {s3, s2, s1, s0}, out_rd, e.a, e.b, e.op, e.rd);
          end
        end
      end
    end
  end

  initial begin
    // Reset with in_valid asserted
    in_valid = 1'b1;
    idle(3);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_a", a, 32'd0);
    check("rst_b", b, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_illegal", 32'(illegal_op), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    idle(2);

    // Single issue
    exp_q.push_back('{a: 32'd1, b: 32'd1, op: 4'b0000, rd: 4'd3});
    send(4'b0000, 4'd3, 4'd1, 4'd2, 32'd1, 32'd1, 32'd0, 1'b0);
    check("single_out_valid", 32'(out_valid), 32'd1);
    idle(3);

    // Forwarding: I2 depends on firing I1; then rd=0 never forwards
    alu_c = 32'h0000_0002;
    exp_q.push_back('{a: 32'd7, b: 32'd8, op: 4'b0000, rd: 4'd5});
    send(4'b0000, 4'd5, 4'd1, 4'd2, 32'd7, 32'd8, 32'd0, 1'b0);
    exp_q.push_back('{a: 32'h2, b: 32'd3, op: 4'b0000, rd: 4'd6});
    send(4'b0000, 4'd6, 4'd5, 4'd6, 32'hDEAD_BEEF, 32'd3, 32'd0, 1'b0);
    exp_q.push_back('{a: 32'd9, b: 32'd1, op: 4'b0001, rd: 4'd0});
    send(4'b0001, 4'd0, 4'd1, 4'd2, 32'd9, 32'd1, 32'd0, 1'b0);
    exp_q.push_back('{a: 32'hDEAD_BEEF, b: 32'd4, op: 4'b1010, rd: 4'd2});
    send(4'b1010, 4'd2, 4'd0, 4'd7, 32'hDEAD_BEEF, 32'd4, 32'd0, 1'b0);
    idle(3);

    // Backpressure: I1 in output, I2 in skid, I3 held at the input
    out_ready = 1'b0;
    alu_c = 32'hAAAA_0001;
    exp_q.push_back('{a: 32'd10, b: 32'd20, op: 4'b1000, rd: 4'd4});
    send(4'b1000, 4'd4, 4'd1, 4'd2, 32'd10, 32'd20, 32'd0, 1'b0);
    exp_q.push_back('{a: 32'hAAAA_0001, b: 32'd5, op: 4'b1001, rd: 4'd7});
    send(4'b1001, 4'd7, 4'd4, 4'd2, 32'hDEAD_BEEF, 32'd5, 32'd0, 1'b0);
    check("skid_full_in_ready", 32'(in_ready), 32'd0);
    drive(4'b1100, 4'd9, 4'd1, 4'd2, 32'h33, 32'h44, 32'd0, 1'b0);
    idle(2);
    check("held_in_ready", 32'(in_ready), 32'd0);
    check("held_out_valid", 32'(out_valid), 32'd1);
    check("held_a", a, 32'd10);
    exp_q.push_back('{a: 32'h33, b: 32'h44, op: 4'b1100, rd: 4'd9});
    out_ready = 1'b1;
    wait_accept();
    idle(3);

    // Reserved ops and sticky flag
    send(4'b0101, 4'd1, 4'd1, 4'd2, 32'd1, 32'd2, 32'd0, 1'b0);
    check("illegal_set", 32'(illegal_op), 32'd1);
    check("illegal_no_issue", 32'(out_valid), 32'd0);
    clr_err = 1'b1;
    send(4'b1111, 4'd1, 4'd1, 4'd2, 32'd1, 32'd2, 32'd0, 1'b0);
    clr_err = 1'b0;
    check("illegal_set_beats_clr", 32'(illegal_op), 32'd1);
    idle(1);
    check("illegal_sticky", 32'(illegal_op), 32'd1);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    check("illegal_cleared", 32'(illegal_op), 32'd0);
    idle(2);

    // Immediate on b is never forwarded
    alu_c = 32'h0000_0002;
    exp_q.push_back('{a: 32'd1, b: 32'd1, op: 4'b0000, rd: 4'd5});
    send(4'b0000, 4'd5, 4'd1, 4'd2, 32'd1, 32'd1, 32'd0, 1'b0);
    exp_q.push_back('{a: 32'h11, b: 32'h0000_FFFF, op: 4'b1101, rd: 4'd8});
    send(4'b1101, 4'd8, 4'd1, 4'd5, 32'h11, 32'hDEAD_BEEF, 32'h0000_FFFF, 1'b1);
    idle(3);

    for (int n = 0; n < 20 && exp_q.size() != 0; n++) idle(1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-operation discards output and skid entries
    out_ready = 1'b0;
    send(4'b0000, 4'd1, 4'd2, 4'd3, 32'd5, 32'd6, 32'd0, 1'b0);
    send(4'b0001, 4'd2, 4'd2, 4'd3, 32'd7, 32'd8, 32'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_a", a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
